// File: rtl/pipeline_hazard_controller.sv
// Pipeline hazard controller: load-use stalls, taken-branch flushes and
// data-memory wait freezes, with a sticky timeout fault (HALT).
// Optional statistics counters are compiled in with `define HAZARD_STATS_EN.
module pipeline_hazard_controller #(
    parameter logic [7:0] MEM_TIMEOUT = 8'd200
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemReadEX,
    input  logic [4:0]  WriteRegEX,
    input  logic [4:0]  RnRegID,
    input  logic [4:0]  RmRegID,
    input  logic        UsesRmID,
    input  logic        BranchTakenEX,
    input  logic        mem_req,
    input  logic        mem_ack,
    output logic        PCWrite,
    output logic        IFIDWrite,
    output logic        IDEXWrite,
    output logic        EXMEMWrite,
    output logic        IFIDFlush,
    output logic        IDEXBubble,
    output logic        MEMWBBubble,
`ifdef HAZARD_STATS_EN
    output logic [15:0] stall_cycles,
    output logic [15:0] flush_count,
`endif
    output logic        MemErr
);

    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_MEM_WAIT = 2'd1;
    localparam logic [1:0] ST_HALT     = 2'd2;

    logic [1:0] state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       load_use;

    // X31 is the zero register, so a load targeting it never creates a dependency.
    assign load_use = MemReadEX && (WriteRegEX != 5'd31) &&
                      ((WriteRegEX == RnRegID) || (UsesRmID && (WriteRegEX == RmRegID)));

    // Next-state, wait counter and pipeline control outputs.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        PCWrite     = 1'b1;
        IFIDWrite   = 1'b1;
        IDEXWrite   = 1'b1;
        EXMEMWrite  = 1'b1;
        IFIDFlush   = 1'b0;
        IDEXBubble  = 1'b0;
        MEMWBBubble = 1'b0;
        MemErr      = 1'b0;

        case (state_q)
            ST_RUN, ST_MEM_WAIT: begin
                if ((state_q == ST_RUN && mem_req && !mem_ack) ||
                    (state_q == ST_MEM_WAIT && !mem_ack)) begin
                    // Memory not ready: freeze everything, drain MEM/WB with a bubble.
                    PCWrite     = 1'b0;
                    IFIDWrite   = 1'b0;
                    IDEXWrite   = 1'b0;
                    EXMEMWrite  = 1'b0;
                    MEMWBBubble = 1'b1;
                    if (state_q == ST_RUN) begin
                        state_d = ST_MEM_WAIT;
                        cnt_d   = 8'd1;
                    end else if (cnt_q == MEM_TIMEOUT) begin
                        state_d = ST_HALT;
                    end else if (cnt_q != '1) begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end else begin
                    // The ack cycle of a wait behaves exactly like a normal RUN cycle.
                    state_d = ST_RUN;
                    cnt_d   = '0;
                    if (BranchTakenEX) begin
                        IFIDFlush  = 1'b1;
                        IDEXBubble = 1'b1;
                    end else if (load_use) begin
                        PCWrite    = 1'b0;
                        IFIDWrite  = 1'b0;
                        IDEXBubble = 1'b1;
                    end
                end
            end
            ST_HALT: begin
                PCWrite     = 1'b0;
                IFIDWrite   = 1'b0;
                IDEXWrite   = 1'b0;
                EXMEMWrite  = 1'b0;
                IFIDFlush   = 1'b1;
                IDEXBubble  = 1'b1;
                MEMWBBubble = 1'b1;
                MemErr      = 1'b1;
            end
            default: begin
                state_d = ST_RUN;
                cnt_d   = '0;
            end
        endcase

        if (reset) begin
            state_d     = ST_RUN;
            cnt_d       = '0;
            PCWrite     = 1'b0;
            IFIDWrite   = 1'b0;
            IDEXWrite   = 1'b0;
            EXMEMWrite  = 1'b0;
            IFIDFlush   = 1'b1;
            IDEXBubble  = 1'b1;
            MEMWBBubble = 1'b1;
            MemErr      = 1'b0;
        end
    end

    // State and wait-counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef HAZARD_STATS_EN
    logic [15:0] stall_q, stall_d;
    logic [15:0] flush_q, flush_d;

    // Saturating stall/flush statistics.
    always_comb begin
        stall_d = stall_q;
        flush_d = flush_q;
        if (!reset && !PCWrite && stall_q != '1)
            stall_d = stall_q + 16'd1;
        if (!reset && IFIDFlush && state_q == ST_RUN && flush_q != '1)
            flush_d = flush_q + 16'd1;
    end

    // Statistics registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

    assign stall_cycles = stall_q;
    assign flush_count  = flush_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Self-checking bench for pipeline_hazard_controller: directed scenarios plus
// randomized stimulus against a behavioural reference model.
module tb_pipeline_hazard_controller;

    localparam int TO = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       MemReadEX;
    logic [4:0] WriteRegEX, RnRegID, RmRegID;
    logic       UsesRmID, BranchTakenEX, mem_req, mem_ack;
    logic       PCWrite, IFIDWrite, IDEXWrite, EXMEMWrite;
    logic       IFIDFlush, IDEXBubble, MEMWBBubble, MemErr;
`ifdef HAZARD_STATS_EN
    logic [15:0] stall_cycles, flush_count;
`endif
    logic [7:0] act;

    int checks = 0;
    int errors = 0;

    // Reference model: mode 0=running, 1=waiting on memory, 2=halted.
    int m_mode   = 0;
    int m_waited = 0;
    int m_stall  = 0;
    int m_flush  = 0;

    always #5 clk = ~clk;

    pipeline_hazard_controller #(.MEM_TIMEOUT(8'd4)) dut (
        .clk(clk), .reset(reset),
        .MemReadEX(MemReadEX), .WriteRegEX(WriteRegEX),
        .RnRegID(RnRegID), .RmRegID(RmRegID), .UsesRmID(UsesRmID),
        .BranchTakenEX(BranchTakenEX), .mem_req(mem_req), .mem_ack(mem_ack),
        .PCWrite(PCWrite), .IFIDWrite(IFIDWrite), .IDEXWrite(IDEXWrite),
        .EXMEMWrite(EXMEMWrite), .IFIDFlush(IFIDFlush), .IDEXBubble(IDEXBubble),
        .MEMWBBubble(MEMWBBubble),
`ifdef HAZARD_STATS_EN
        .stall_cycles(stall_cycles), .flush_count(flush_count),
`endif
        .MemErr(MemErr)
    );

    // {PCWrite, IFIDWrite, IDEXWrite, EXMEMWrite, IFIDFlush, IDEXBubble, MEMWBBubble, MemErr}
    assign act = {PCWrite, IFIDWrite, IDEXWrite, EXMEMWrite,
                  IFIDFlush, IDEXBubble, MEMWBBubble, MemErr};

    function logic hazard_now();
        return MemReadEX && (WriteRegEX != 5'd31) &&
               ((WriteRegEX == RnRegID) || (UsesRmID && (WriteRegEX == RmRegID)));
    endfunction

    function logic [7:0] model_outs();
        if (reset)       return 8'b0000_1110;
        if (m_mode == 2) return 8'b0000_1111;
        if ((m_mode == 0 && mem_req && !mem_ack) || (m_mode == 1 && !mem_ack))
            return 8'b0000_0010;
        if (BranchTakenEX) return 8'b1111_1100;
        if (hazard_now())  return 8'b0011_0100;
        return 8'b1111_0000;
    endfunction

    task set_idle();
        MemReadEX = 0; WriteRegEX = 0; RnRegID = 0; RmRegID = 0; UsesRmID = 0;
        BranchTakenEX = 0; mem_req = 0; mem_ack = 0;
    endtask

    // Update the model with the current cycle's inputs, then clock the DUT.
    task advance();
        logic [7:0] e;
        e = model_outs();
        if (reset) begin
            m_mode = 0; m_waited = 0; m_stall = 0; m_flush = 0;
        end else begin
            if (!e[7] && m_stall < 65535) m_stall++;
            if (e[3] && m_mode == 0 && m_flush < 65535) m_flush++;
            if (m_mode == 0) begin
                if (mem_req && !mem_ack) begin m_mode = 1; m_waited = 1; end
            end else if (m_mode == 1) begin
                if (mem_ack)              begin m_mode = 0; m_waited = 0; end
                else if (m_waited == TO)  m_mode = 2;
                else                      m_waited++;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task test_reset();
        reset = 1;
        for (int i = 0; i < 4; i++) begin
            MemReadEX = 1'($urandom); WriteRegEX = 5'($urandom); RnRegID = 5'($urandom);
            RmRegID = 5'($urandom); UsesRmID = 1'($urandom); BranchTakenEX = 1'($urandom);
            mem_req = 1'($urandom); mem_ack = 1'($urandom);
            #1; checks++;
            if (act !== 8'b0000_1110) begin
                errors++; $display("FAIL reset_outputs act=%b exp=%b", act, 8'b0000_1110);
            end
            advance();
        end
        reset = 0; set_idle(); #1; checks++;
        if (act !== 8'b1111_0000) begin
            errors++; $display("FAIL after_reset_run act=%b exp=%b", act, 8'b1111_0000);
        end
        advance();
    endtask

    task test_load_use();
        MemReadEX = 1; WriteRegEX = 3; RnRegID = 3; #1; checks++;
        if (act !== 8'b0011_0100) begin
            errors++; $display("FAIL load_use_stall act=%b exp=%b", act, 8'b0011_0100);
        end
        advance();
        // The bubble moved into EX, so the load has left EX.
        MemReadEX = 0; #1; checks++;
        if (act !== 8'b1111_0000) begin
            errors++; $display("FAIL load_use_one_cycle act=%b exp=%b", act, 8'b1111_0000);
        end
        advance();
        MemReadEX = 1; WriteRegEX = 31; RnRegID = 31; #1; checks++;
        if (act !== 8'b1111_0000) begin
            errors++; $display("FAIL load_use_x31 act=%b exp=%b", act, 8'b1111_0000);
        end
        advance();
        WriteRegEX = 4; RnRegID = 1; RmRegID = 4; UsesRmID = 0; #1; checks++;
        if (act !== 8'b1111_0000) begin
            errors++; $display("FAIL load_use_rm_unused act=%b exp=%b", act, 8'b1111_0000);
        end
        UsesRmID = 1; #1; checks++;
        if (act !== 8'b0011_0100) begin
            errors++; $display("FAIL load_use_rm act=%b exp=%b", act, 8'b0011_0100);
        end
        advance();
        set_idle();
    endtask

    task test_branch();
        BranchTakenEX = 1; MemReadEX = 1; WriteRegEX = 5; RnRegID = 5; #1; checks++;
        if (act !== 8'b1111_1100) begin
            errors++; $display("FAIL branch_over_hazard act=%b exp=%b", act, 8'b1111_1100);
        end
        advance();
        set_idle();
    endtask

    task test_mem_wait();
        mem_req = 1; mem_ack = 0;
        for (int i = 0; i < 3; i++) begin
            // Branch and hazard inputs must be ignored while frozen.
            BranchTakenEX = (i == 1); MemReadEX = (i == 2); WriteRegEX = 7; RnRegID = 7;
            #1; checks++;
            if (act !== 8'b0000_0010) begin
                errors++; $display("FAIL mem_freeze_%0d act=%b exp=%b", i, act, 8'b0000_0010);
            end
            advance();
        end
        BranchTakenEX = 0; MemReadEX = 0; mem_ack = 1; #1; checks++;
        if (act !== 8'b1111_0000) begin
            errors++; $display("FAIL mem_ack_advance act=%b exp=%b", act, 8'b1111_0000);
        end
        advance();
        // Single-cycle access while running: no stall.
        #1; checks++;
        if (act !== 8'b1111_0000) begin
            errors++; $display("FAIL mem_single_cycle act=%b exp=%b", act, 8'b1111_0000);
        end
        advance();
        mem_ack = 0; advance();
        // Ack cycle with a load-use hazard applies the normal stall.
        mem_ack = 1; MemReadEX = 1; WriteRegEX = 9; RnRegID = 9; #1; checks++;
        if (act !== 8'b0011_0100) begin
            errors++; $display("FAIL mem_ack_hazard act=%b exp=%b", act, 8'b0011_0100);
        end
        advance();
        set_idle(); #1; checks++;
        if (act !== 8'b1111_0000) begin
            errors++; $display("FAIL mem_back_to_run act=%b exp=%b", act, 8'b1111_0000);
        end
        advance();
    endtask

    task test_timeout();
        mem_req = 1; mem_ack = 0;
        // One entry cycle plus TO counted wait cycles before the fault.
        for (int i = 0; i <= TO; i++) begin
            #1; checks++;
            if (act !== 8'b0000_0010) begin
                errors++; $display("FAIL timeout_wait_%0d act=%b exp=%b", i, act, 8'b0000_0010);
            end
            advance();
        end
        for (int i = 0; i < 3; i++) begin
            mem_ack = (i != 0); BranchTakenEX = (i == 2); #1; checks++;
            if (act !== 8'b0000_1111) begin
                errors++; $display("FAIL halt_sticky_%0d act=%b exp=%b", i, act, 8'b0000_1111);
            end
            advance();
        end
        reset = 1; #1; checks++;
        if (act !== 8'b0000_1110) begin
            errors++; $display("FAIL halt_reset act=%b exp=%b", act, 8'b0000_1110);
        end
        advance();
        reset = 0; set_idle(); #1; checks++;
        if (act !== 8'b1111_0000) begin
            errors++; $display("FAIL halt_recovered act=%b exp=%b", act, 8'b1111_0000);
        end
        advance();
    endtask

`ifdef HAZARD_STATS_EN
    task test_stats();
        reset = 1; advance(); reset = 0; set_idle();
        for (int i = 0; i < 2; i++) begin
            MemReadEX = 1; WriteRegEX = 2; RnRegID = 2; advance();
            set_idle(); advance();
        end
        BranchTakenEX = 1; advance();
        set_idle(); #1; checks++;
        if (stall_cycles !== 16'd2 || flush_count !== 16'd1) begin
            errors++;
            $display("FAIL stats_counts act=%0d/%0d exp=2/1", stall_cycles, flush_count);
        end
    endtask
`endif

    task test_random();
        logic [7:0] e;
        reset = 1; advance(); reset = 0;
        for (int i = 0; i < 600; i++) begin
            reset         = ($urandom_range(0, 99) < 2);
            MemReadEX     = 1'($urandom);
            WriteRegEX    = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 5));
            RnRegID       = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 5));
            RmRegID       = 5'($urandom_range(0, 5));
            UsesRmID      = 1'($urandom);
            BranchTakenEX = ($urandom_range(0, 4) == 0);
            mem_req       = ($urandom_range(0, 3) == 0);
            mem_ack       = ($urandom_range(0, 9) < 6);
            #1;
            e = model_outs();
            checks++;
            if (act !== e) begin
                errors++; $display("FAIL random_%0d act=%b exp=%b", i, act, e);
            end
`ifdef HAZARD_STATS_EN
            checks++;
            if (stall_cycles !== 16'(m_stall) || flush_count !== 16'(m_flush)) begin
                errors++;
                $display("FAIL random_stats_%0d act=%0d/%0d exp=%0d/%0d",
                         i, stall_cycles, flush_count, m_stall, m_flush);
            end
`endif
            advance();
        end
        reset = 0; set_idle();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        set_idle();
        reset = 1;
        @(negedge clk);
        test_reset();
        test_load_use();
        test_branch();
        test_mem_wait();
        test_timeout();
`ifdef HAZARD_STATS_EN
        test_stats();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
